memristive_op_sequencer: RTL and testbench
==========================================

Name: memristive_op_sequencer

Overview:
- Controller that sequences in-memory logic operations (AND, NOR, NOT, READ) on a memristor crossbar row set.
- Accepts one command at a time over a valid/ready handshake.
- Drives row selects and a voltage-mode bus through INIT, EVAL and READ phases, then returns the sensed result of the destination cell.
- Sits between the PIM command front-end and the crossbar drivers that feed the memristive gate cells.

Parameters:
ADDR_W, 4, width of each row address
INIT_CYCLES, 2, cycles the destination cell is held at the init voltage (>=1)
EVAL_CYCLES, 4, cycles the gate evaluation bias is applied (>=1)
READ_CYCLES, 1, cycles of read bias; sense_in is sampled on the last one (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  2  00 AND, 01 NOR, 10 NOT, 11 READ
cmd_a  in  ADDR_W  operand A row
cmd_b  in  ADDR_W  operand B row (ignored for NOT and READ)
cmd_dst  in  ADDR_W  destination row (ignored for READ)
row_sel_a  out  ADDR_W  latched A row
row_sel_b  out  ADDR_W  latched B row
row_sel_dst  out  ADDR_W  latched destination row
drv_a_en  out  1  drive enable, row A
drv_b_en  out  1  drive enable, row B
drv_dst_en  out  1  drive enable, destination row
v_mode  out  2  00 ground, 01 SET (write 1), 10 RESET (write 0), 11 EVAL/READ bias
sense_in  in  1  sense-amp output for the currently read row
busy  out  1  high whenever state != IDLE
done  out  1  one-cycle completion pulse
result  out  1  sensed value, valid from done until the next accept
err  out  1  illegal command flag, valid with result

Behaviour:
- Reset (asynchronous, any state):
  - state=IDLE; phase counter=0.
  - All drv_*_en=0, v_mode=00, row_sel_*=0.
  - done=0, result=0, err=0, busy=0, cmd_ready=1.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on a rising edge with cmd_valid & cmd_ready.
  - Operands and op are latched at accept; inputs are ignored while busy.
- Legality check at accept:
  - AND/NOR: illegal if cmd_dst==cmd_a or cmd_dst==cmd_b.
  - NOT: illegal if cmd_dst==cmd_a.
  - READ: always legal.
  - Illegal commands go straight to DONE with err=1, result=0, and no drive activity.
- States:
  - IDLE: outputs quiescent. Accept leads to INIT (AND/NOR/NOT), READ (READ op), or DONE (illegal).
  - INIT, for INIT_CYCLES cycles:
    - drv_dst_en=1.
    - v_mode=10 for AND; v_mode=01 for NOR/NOT.
    - Then EVAL.
  - EVAL, for EVAL_CYCLES cycles:
    - v_mode=11, drv_a_en=1, drv_dst_en=1.
    - drv_b_en=1 for AND/NOR only.
    - Then READ.
  - READ, for READ_CYCLES cycles:
    - v_mode=11, one row driven: drv_dst_en=1 for gate ops, drv_a_en=1 for the READ op.
    - sense_in is sampled into result on the last READ cycle.
    - Then DONE.
  - DONE, exactly 1 cycle: done=1, drives off, v_mode=00, then IDLE.
- Drive rules:
  - Drive enables and v_mode are registered; they change only on state/counter edges.
  - No drive enable is ever high while v_mode=00.
- Latency, accept edge to done-high cycle:
  - Gate op: INIT_CYCLES+EVAL_CYCLES+READ_CYCLES+1 cycles (defaults: 8).
  - READ op: READ_CYCLES+1.
  - Illegal op: 1.
- Throughput: the next command can be accepted in the cycle after done (IDLE). No back-to-back accept during DONE.
- Phase counter: clog2 of the max phase length. Reloads to 0 on every state transition and never wraps within a phase.
- row_sel_* hold their latched values until the next accept, including through DONE and IDLE.
- Reset mid-operation: drives drop in the same instant as rst; the interrupted command is discarded with no done pulse.

Optional Feature:
- Macro: MEM_OPCOUNT_EN.
- Defined:
  - Adds output op_count [15:0], reset to 0.
  - Increments on each done pulse with err=0; saturates at 16'hFFFF.
  - Adds output err_count [7:0], incrementing on each done with err=1; saturates at 8'hFF.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> all outputs 0 immediately, cmd_ready=1, busy=0.
- AND a=1 b=2 dst=3, defaults, sense_in=1 in READ -> INIT 2 cycles v_mode=10 drv_dst only; EVAL 4 cycles v_mode=11 all three drives; READ 1 cycle; done 8 cycles after accept with result=1, err=0.
- NOT a=5 dst=6, sense_in=0 -> INIT v_mode=01; EVAL drv_b_en=0 throughout; result=0.
- READ a=9, sense_in=1 -> only drv_a_en high with v_mode=11 for 1 cycle; done 2 cycles after accept; result=1.
- NOR a=4 b=7 dst=7 -> done the cycle after accept, err=1, result=0, no drive enable ever high.
- rst asserted during EVAL of an AND -> drives drop at once, no done pulse; a following READ completes normally. With MEM_OPCOUNT_EN, op_count counts only completed legal ops.

Source files
------------

// File: rtl/memristive_op_sequencer.sv
// memristive_op_sequencer: sequences AND/NOR/NOT/READ on a memristor crossbar row set.
// Latency: accept to done = INIT+EVAL+READ+1 (gate), READ+1 (read), 1 (illegal).
// Backpressure: cmd_ready only in IDLE; one command in flight, inputs ignored while busy.
// Ports: clk/rst, cmd_* valid/ready command in, row_sel_*/drv_*_en/v_mode to the crossbar
// drivers, sense_in from the sense amp, busy/done/result/err status.
// Optional macro MEM_OPCOUNT_EN adds op_count/err_count completion counters.
module memristive_op_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int INIT_CYCLES = 2,
  parameter int EVAL_CYCLES = 4,
  parameter int READ_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [ADDR_W-1:0] cmd_dst,
  output logic [ADDR_W-1:0] row_sel_a,
  output logic [ADDR_W-1:0] row_sel_b,
  output logic [ADDR_W-1:0] row_sel_dst,
  output logic              drv_a_en,
  output logic              drv_b_en,
  output logic              drv_dst_en,
  output logic [1:0]        v_mode,
  input  logic              sense_in,
  output logic              busy,
  output logic              done,
  output logic              result,
`ifdef MEM_OPCOUNT_EN
  output logic [15:0]       op_count,
  output logic [7:0]        err_count,
`endif
  output logic              err
);

  localparam int MAX_A = (INIT_CYCLES > EVAL_CYCLES) ? INIT_CYCLES : EVAL_CYCLES;
  localparam int MAXC  = (MAX_A > READ_CYCLES) ? MAX_A : READ_CYCLES;
  localparam int CW    = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(EVAL_CYCLES - 1);
  localparam logic [CW-1:0] READ_LAST = CW'(READ_CYCLES - 1);

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_NOT  = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  localparam logic [1:0] VM_GND  = 2'b00;
  localparam logic [1:0] VM_SET  = 2'b01;
  localparam logic [1:0] VM_RST  = 2'b10;
  localparam logic [1:0] VM_BIAS = 2'b11;

  typedef enum logic [2:0] {S_IDLE, S_INIT, S_EVAL, S_READ, S_DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    op_q;
  logic          illegal;

  // Destination must not alias an operand it is evaluated from.
  always_comb begin
    illegal = 1'b0;
    case (cmd_op)
      2'b00, 2'b01: illegal = (cmd_dst == cmd_a) || (cmd_dst == cmd_b);
      2'b10:        illegal = (cmd_dst == cmd_a);
      default:      illegal = 1'b0;
    endcase
  end

  assign cmd_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  // Outputs are loaded on the edge that enters each phase, so drives and
  // v_mode always line up with the state they belong to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= 2'b00;
      row_sel_a   <= '0;
      row_sel_b   <= '0;
      row_sel_dst <= '0;
      drv_a_en    <= 1'b0;
      drv_b_en    <= 1'b0;
      drv_dst_en  <= 1'b0;
      v_mode      <= VM_GND;
      done        <= 1'b0;
      result      <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q        <= cmd_op;
            row_sel_a   <= cmd_a;
            row_sel_b   <= cmd_b;
            row_sel_dst <= cmd_dst;
            cnt         <= '0;
            result      <= 1'b0;
            err         <= illegal;
            if (illegal) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (cmd_op == OP_READ) begin
              state    <= S_READ;
              v_mode   <= VM_BIAS;
              drv_a_en <= 1'b1;
            end else begin
              state      <= S_INIT;
              drv_dst_en <= 1'b1;
              // AND starts from a RESET destination, NOR/NOT from a SET one.
              v_mode     <= (cmd_op == OP_AND) ? VM_RST : VM_SET;
            end
          end
        end
        S_INIT: begin
          if (cnt == INIT_LAST) begin
            cnt        <= '0;
            state      <= S_EVAL;
            v_mode     <= VM_BIAS;
            drv_a_en   <= 1'b1;
            drv_b_en   <= (op_q != OP_NOT);
            drv_dst_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_EVAL: begin
          if (cnt == EVAL_LAST) begin
            cnt        <= '0;
            state      <= S_READ;
            drv_a_en   <= 1'b0;
            drv_b_en   <= 1'b0;
            drv_dst_en <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READ: begin
          if (cnt == READ_LAST) begin
            cnt        <= '0;
            state      <= S_DONE;
            result     <= sense_in;
            done       <= 1'b1;
            drv_a_en   <= 1'b0;
            drv_b_en   <= 1'b0;
            drv_dst_en <= 1'b0;
            v_mode     <= VM_GND;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef MEM_OPCOUNT_EN
  // Counted on the done pulse; both counters stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count  <= '0;
      err_count <= '0;
    end else if (done) begin
      if (!err && op_count != 16'hFFFF)
        op_count <= op_count + 16'd1;
      if (err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_memristive_op_sequencer.sv
module tb_memristive_op_sequencer;

  localparam int I = 2;
  localparam int E = 4;
  localparam int R = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_a = 4'd0;
  logic [3:0] cmd_b = 4'd0;
  logic [3:0] cmd_dst = 4'd0;
  logic [3:0] row_sel_a, row_sel_b, row_sel_dst;
  logic       drv_a_en, drv_b_en, drv_dst_en;
  logic [1:0] v_mode;
  logic       sense_in = 1'b0;
  logic       busy, done, result, err;
`ifdef MEM_OPCOUNT_EN
  logic [15:0] op_count;
  logic [7:0]  err_count;
`endif

  int total = 0;
  int bad   = 0;
  int exp_ops  = 0;
  int exp_errs = 0;

  typedef struct {
    logic       res;
    logic       err;
    logic [3:0] a;
  } exp_t;
  exp_t sb[$];

  memristive_op_sequencer #(
    .ADDR_W(4), .INIT_CYCLES(I), .EVAL_CYCLES(E), .READ_CYCLES(R)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_dst(cmd_dst),
    .row_sel_a(row_sel_a), .row_sel_b(row_sel_b), .row_sel_dst(row_sel_dst),
    .drv_a_en(drv_a_en), .drv_b_en(drv_b_en), .drv_dst_en(drv_dst_en),
    .v_mode(v_mode), .sense_in(sense_in),
    .busy(busy), .done(done), .result(result),
`ifdef MEM_OPCOUNT_EN
    .op_count(op_count), .err_count(err_count),
`endif
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest issued command.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", 32'(result), 32'(e.res));
        check("err", 32'(err), 32'(e.err));
        check("rsel_a_at_done", 32'(row_sel_a), 32'(e.a));
      end
    end
  end

  // Crossbar safety: grounded bus means nothing may be driven.
  always @(negedge clk) begin
    if (!rst && v_mode == 2'b00)
      check("drive_on_gnd", {29'd0, drv_a_en, drv_b_en, drv_dst_en}, 32'd0);
  end

  task automatic check_counts();
`ifdef MEM_OPCOUNT_EN
    check("op_count", 32'(op_count), 32'(exp_ops));
    check("err_count", 32'(err_count), 32'(exp_errs));
`endif
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_drv"}, {29'd0, drv_a_en, drv_b_en, drv_dst_en}, 32'd0);
    check({tag, "_vmode"}, 32'(v_mode), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic run_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] dst, input logic s);
    logic       ill;
    int         lat;
    int         k;
    logic [1:0] evm;
    logic [2:0] edrv;
    ill = (op == 2'b00 || op == 2'b01) ? (dst == a || dst == b) :
          (op == 2'b10) ? (dst == a) : 1'b0;
    lat = ill ? 1 : (op == 2'b11) ? R + 1 : I + E + R + 1;
    @(negedge clk);
    check("ready_before", 32'(cmd_ready), 32'd1);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_dst = dst;
    cmd_valid = 1'b1;
    sense_in = (lat == 1) ? s : ~s;
    sb.push_back('{res: ill ? 1'b0 : s, err: ill, a: a});
    @(posedge clk);
    #1;
    // Hold valid and scramble operands: both must be ignored while busy.
    cmd_a = ~a; cmd_b = ~b; cmd_dst = ~dst; cmd_op = ~op;
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (done) break;
      // sense_in only carries the real value during the final READ cycle.
      sense_in = (k == lat - 1) ? s : ~s;
      if (op == 2'b11) begin
        evm = 2'b11; edrv = 3'b100;
      end else if (k <= I) begin
        evm = (op == 2'b00) ? 2'b10 : 2'b01; edrv = 3'b001;
      end else if (k <= I + E) begin
        evm = 2'b11; edrv = {1'b1, op != 2'b10, 1'b1};
      end else begin
        evm = 2'b11; edrv = 3'b001;
      end
      check("v_mode", 32'(v_mode), 32'(evm));
      check("drives", {29'd0, drv_a_en, drv_b_en, drv_dst_en}, 32'(edrv));
      check("busy", 32'(busy), 32'd1);
      check("ready_busy", 32'(cmd_ready), 32'd0);
    end
    cmd_valid = 1'b0;
    check("latency", 32'(k), 32'(lat));
    check("done_vmode", 32'(v_mode), 32'd0);
    if (ill) exp_errs++; else exp_ops++;
    @(negedge clk);
    check_quiet("after_done");
    check("rsel_dst_hold", 32'(row_sel_dst), 32'(dst));
    check("rsel_b_hold", 32'(row_sel_b), 32'(b));
    check_counts();
  endtask

  initial begin
    #3 rst = 1'b1;
    #1;
    check_quiet("reset");
    check("reset_result", 32'(result), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_rsel", {20'd0, row_sel_a, row_sel_b, row_sel_dst}, 32'd0);
    check_counts();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_cmd(2'b00, 4'd1, 4'd2, 4'd3, 1'b1);   // AND
    run_cmd(2'b10, 4'd5, 4'd0, 4'd6, 1'b0);   // NOT
    run_cmd(2'b11, 4'd9, 4'd0, 4'd0, 1'b1);   // READ
    run_cmd(2'b01, 4'd4, 4'd7, 4'd7, 1'b1);   // NOR illegal dst==b
    run_cmd(2'b00, 4'd8, 4'd2, 4'd8, 1'b1);   // AND illegal dst==a
    run_cmd(2'b10, 4'd2, 4'd3, 4'd3, 1'b1);   // NOT, b ignored -> legal
    run_cmd(2'b11, 4'd6, 4'd6, 4'd6, 1'b0);   // READ never illegal
    run_cmd(2'b01, 4'd0, 4'd15, 4'd10, 1'b0); // NOR legal
    run_cmd(2'b00, 4'd12, 4'd13, 4'd14, 1'b0);

    // Abort an AND during EVAL; nothing pushed, so any done is flagged.
    @(negedge clk);
    cmd_op = 2'b00; cmd_a = 4'd1; cmd_b = 4'd2; cmd_dst = 4'd3; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_eval_drv", {29'd0, drv_a_en, drv_b_en, drv_dst_en}, 32'd7);
    #2 rst = 1'b1;
    #1;
    check_quiet("abort");
    exp_ops = 0; exp_errs = 0;
    check_counts();
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("abort_no_done", 32'(done), 32'd0);
    end
    run_cmd(2'b11, 4'd9, 4'd0, 4'd0, 1'b1);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
